// File: rtl/muldiv_iter_unit.sv
// Iterative radix-2 multiply/divide unit that owns the HI/LO register pair for the EX stage.
// Define MULDIV_MADD_EN to enable the MADD/MSUB accumulate ops (iOp 110/111).
module muldiv_iter_unit #(
    parameter int ITER = 32
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic        iStart,
    input  logic [2:0]  iOp,
    input  logic [31:0] iA,
    input  logic [31:0] iB,
    output logic        oBusy,
    output logic        oDone,
    output logic        oDivZero,
    output logic [31:0] oHI,
    output logic [31:0] oLO
);

    localparam int CNT_W = $clog2(ITER);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ITER - 1);

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;
    localparam logic [2:0] OP_MADD  = 3'b110;
    localparam logic [2:0] OP_MSUB  = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2
    } state_t;

    function automatic logic [31:0] cond_neg32(input logic neg, input logic [31:0] val);
        cond_neg32 = neg ? (32'd0 - val) : val;
    endfunction

    function automatic logic [63:0] cond_neg64(input logic neg, input logic [63:0] val);
        cond_neg64 = neg ? (64'd0 - val) : val;
    endfunction

    state_t             state_r;
    state_t             next_state_s;
    logic [CNT_W-1:0]   cnt_r;
    logic [2:0]         op_r;
    logic               sign_a_r;
    logic               sign_b_r;
    logic               div_zero_pend_r;
    logic [31:0]        mag_a_r;
    logic [31:0]        mag_b_r;
    logic [31:0]        work_hi_r;
    logic [31:0]        work_lo_r;
    logic               busy_r;
    logic               done_r;
    logic               div_zero_r;
    logic [31:0]        hi_r;
    logic [31:0]        lo_r;

    logic               is_iter_op_s;
    logic               is_signed_op_s;
    logic               in_is_div_s;
    logic               in_sign_a_s;
    logic               in_sign_b_s;
    logic [31:0]        in_mag_a_s;
    logic [31:0]        in_mag_b_s;
    logic               accept_s;
    logic               mthi_s;
    logic               mtlo_s;
    logic               step_s;
    logic               fix_s;
    logic               op_is_div_s;
    logic [32:0]        mul_sum_s;
    logic [32:0]        div_shift_s;
    logic [33:0]        div_diff_s;
    logic [31:0]        step_hi_s;
    logic [31:0]        step_lo_s;
    logic [63:0]        sprod_s;
    logic [31:0]        quo_s;
    logic [31:0]        rem_s;
    logic [31:0]        raw_a_s;
    logic [31:0]        res_hi_s;
    logic [31:0]        res_lo_s;

    // Decode the requested op and form operand magnitudes for signed ops.
    always_comb begin
        is_iter_op_s   = 1'b0;
        is_signed_op_s = 1'b0;
        case (iOp)
            OP_MULT, OP_DIV: begin
                is_iter_op_s   = 1'b1;
                is_signed_op_s = 1'b1;
            end
            OP_MULTU, OP_DIVU: begin
                is_iter_op_s   = 1'b1;
                is_signed_op_s = 1'b0;
            end
            OP_MADD, OP_MSUB: begin
`ifdef MULDIV_MADD_EN
                is_iter_op_s   = 1'b1;
                is_signed_op_s = 1'b1;
`else
                is_iter_op_s   = 1'b0;
                is_signed_op_s = 1'b0;
`endif
            end
            default: begin
                is_iter_op_s   = 1'b0;
                is_signed_op_s = 1'b0;
            end
        endcase
        in_is_div_s = (iOp == OP_DIV) || (iOp == OP_DIVU);
        in_sign_a_s = is_signed_op_s & iA[31];
        in_sign_b_s = is_signed_op_s & iB[31];
        in_mag_a_s  = cond_neg32(in_sign_a_s, iA);
        in_mag_b_s  = cond_neg32(in_sign_b_s, iB);
    end

    // State register; reset aborts any op in flight.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic: IDLE -> CALC (ITER steps) -> FIX -> IDLE.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (iStart && is_iter_op_s) begin
                    next_state_s = ST_CALC;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_CALC: begin
                if (cnt_r == LAST_CNT) begin
                    next_state_s = ST_FIX;
                end else begin
                    next_state_s = ST_CALC;
                end
            end
            ST_FIX:  next_state_s = ST_IDLE;
            default: next_state_s = ST_IDLE;
        endcase
    end

    // Control strobes per state; iStart only matters in IDLE.
    always_comb begin
        accept_s = 1'b0;
        mthi_s   = 1'b0;
        mtlo_s   = 1'b0;
        step_s   = 1'b0;
        fix_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                accept_s = iStart && is_iter_op_s;
                mthi_s   = iStart && (iOp == OP_MTHI);
                mtlo_s   = iStart && (iOp == OP_MTLO);
            end
            ST_CALC: step_s = 1'b1;
            ST_FIX:  fix_s  = 1'b1;
            default: begin
                accept_s = 1'b0;
                step_s   = 1'b0;
            end
        endcase
    end

    // One radix-2 step: shift-add for multiply, restoring shift-subtract for divide.
    always_comb begin
        op_is_div_s = (op_r == OP_DIV) || (op_r == OP_DIVU);
        mul_sum_s   = {1'b0, work_hi_r} + (work_lo_r[0] ? {1'b0, mag_a_r} : 33'd0);
        div_shift_s = {work_hi_r, work_lo_r[31]};
        div_diff_s  = {1'b0, div_shift_s} - {2'b00, mag_b_r};
        if (op_is_div_s) begin
            step_hi_s = div_diff_s[33] ? div_shift_s[31:0] : div_diff_s[31:0];
            step_lo_s = {work_lo_r[30:0], ~div_diff_s[33]};
        end else begin
            step_hi_s = mul_sum_s[32:1];
            step_lo_s = {mul_sum_s[0], work_lo_r[31:1]};
        end
    end

    // Sign correction and final HI/LO selection applied in FIX.
    always_comb begin
        sprod_s  = cond_neg64(sign_a_r ^ sign_b_r, {work_hi_r, work_lo_r});
        quo_s    = cond_neg32(sign_a_r ^ sign_b_r, work_lo_r);
        rem_s    = cond_neg32(sign_a_r, work_hi_r);
        raw_a_s  = cond_neg32(sign_a_r, mag_a_r);
        res_hi_s = hi_r;
        res_lo_s = lo_r;
        case (op_r)
            OP_MULT, OP_MULTU: begin
                {res_hi_s, res_lo_s} = sprod_s;
            end
            OP_DIV, OP_DIVU: begin
                if (div_zero_pend_r) begin
                    res_hi_s = raw_a_s;
                    res_lo_s = 32'hFFFF_FFFF;
                end else begin
                    res_hi_s = rem_s;
                    res_lo_s = quo_s;
                end
            end
`ifdef MULDIV_MADD_EN
            OP_MADD: {res_hi_s, res_lo_s} = {hi_r, lo_r} + sprod_s;
            OP_MSUB: {res_hi_s, res_lo_s} = {hi_r, lo_r} - sprod_s;
`endif
            default: {res_hi_s, res_lo_s} = {hi_r, lo_r};
        endcase
    end

    // Datapath and registered outputs; HI/LO only change on MTHI/MTLO or in FIX.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            cnt_r           <= '0;
            op_r            <= 3'b000;
            sign_a_r        <= 1'b0;
            sign_b_r        <= 1'b0;
            div_zero_pend_r <= 1'b0;
            mag_a_r         <= 32'd0;
            mag_b_r         <= 32'd0;
            work_hi_r       <= 32'd0;
            work_lo_r       <= 32'd0;
            busy_r          <= 1'b0;
            done_r          <= 1'b0;
            div_zero_r      <= 1'b0;
            hi_r            <= 32'd0;
            lo_r            <= 32'd0;
        end else begin
            if (accept_s) begin
                op_r            <= iOp;
                sign_a_r        <= in_sign_a_s;
                sign_b_r        <= in_sign_b_s;
                mag_a_r         <= in_mag_a_s;
                mag_b_r         <= in_mag_b_s;
                work_hi_r       <= 32'd0;
                work_lo_r       <= in_is_div_s ? in_mag_a_s : in_mag_b_s;
                div_zero_pend_r <= in_is_div_s && (iB == 32'd0);
                div_zero_r      <= 1'b0;
                cnt_r           <= '0;
            end else if (step_s) begin
                work_hi_r <= step_hi_s;
                work_lo_r <= step_lo_s;
                cnt_r     <= cnt_r + CNT_W'(1);
            end else if (fix_s) begin
                hi_r       <= res_hi_s;
                lo_r       <= res_lo_s;
                div_zero_r <= div_zero_pend_r;
            end else begin
                if (mthi_s) begin
                    hi_r <= iA;
                end
                if (mtlo_s) begin
                    lo_r <= iA;
                end
            end
            busy_r <= (next_state_s != ST_IDLE);
            done_r <= fix_s;
        end
    end

    assign oBusy    = busy_r;
    assign oDone    = done_r;
    assign oDivZero = div_zero_r;
    assign oHI      = hi_r;
    assign oLO      = lo_r;

endmodule

// File: tb/tb_muldiv_iter_unit.sv
// Scoreboard bench for muldiv_iter_unit: directed vectors, expected HI/LO/DivZero queued at issue.
// Build with MULDIV_MADD_EN defined to exercise MADD/MSUB; otherwise checks they are ignored.
module tb_muldiv_iter_unit;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;
    localparam logic [2:0] OP_MADD  = 3'b110;
    localparam logic [2:0] OP_MSUB  = 3'b111;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
    } exp_t;

    logic        iCLK;
    logic        iRST;
    logic        iStart;
    logic [2:0]  iOp;
    logic [31:0] iA;
    logic [31:0] iB;
    logic        oBusy;
    logic        oDone;
    logic        oDivZero;
    logic [31:0] oHI;
    logic [31:0] oLO;

    exp_t        exp_q[$];
    int          compared;
    int          mismatched;
    logic [31:0] model_hi;
    logic [31:0] model_lo;

    muldiv_iter_unit dut (
        .iCLK     (iCLK),
        .iRST     (iRST),
        .iStart   (iStart),
        .iOp      (iOp),
        .iA       (iA),
        .iB       (iB),
        .oBusy    (oBusy),
        .oDone    (oDone),
        .oDivZero (oDivZero),
        .oHI      (oHI),
        .oLO      (oLO)
    );

    initial iCLK = 1'b0;
    always #5 iCLK = ~iCLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        compared++;
        if (act !== expv) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    // Monitor: every done pulse must match the oldest queued expectation.
    always @(negedge iCLK) begin
        if (oDone === 1'b1) begin
            if (exp_q.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL unexpected_done: got oDone=1 expected no pulse at %0t", $time);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("result_hi", oHI, e.hi);
                check("result_lo", oLO, e.lo);
                check("result_divzero", {31'd0, oDivZero}, {31'd0, e.dz});
            end
        end
    end

    task automatic run_iter(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] eh, input logic [31:0] el, input logic edz,
                            input int inject);
        int busy_cnt;
        exp_t e;
        e.hi = eh;
        e.lo = el;
        e.dz = edz;
        exp_q.push_back(e);
        @(negedge iCLK);
        iStart = 1'b1;
        iOp    = op;
        iA     = a;
        iB     = b;
        @(negedge iCLK);
        iStart = 1'b0;
        iA     = ~a;
        iB     = ~b;
        check("divzero_cleared_at_start", {31'd0, oDivZero}, 32'd0);
        check("hi_held_during_calc", oHI, model_hi);
        busy_cnt = 0;
        while (oBusy === 1'b1 && busy_cnt < 100) begin
            busy_cnt++;
            if (busy_cnt == inject) begin
                iStart = 1'b1;
                iOp    = OP_DIVU;
                iA     = 32'd7;
                iB     = 32'd1;
            end else begin
                iStart = 1'b0;
            end
            if (busy_cnt == 20) begin
                check("lo_held_during_calc", oLO, model_lo);
            end
            @(negedge iCLK);
        end
        iStart = 1'b0;
        check("busy_cycles", busy_cnt, 32'd33);
        model_hi = eh;
        model_lo = el;
        @(negedge iCLK);
        check("done_single_cycle", {31'd0, oDone}, 32'd0);
    endtask

    task automatic move_to(input logic [2:0] op, input logic [31:0] a);
        @(negedge iCLK);
        iStart = 1'b1;
        iOp    = op;
        iA     = a;
        @(negedge iCLK);
        iStart = 1'b0;
        if (op == OP_MTHI) begin
            model_hi = a;
        end else begin
            model_lo = a;
        end
        check("mt_no_busy", {31'd0, oBusy}, 32'd0);
        check("mt_hi", oHI, model_hi);
        check("mt_lo", oLO, model_lo);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        compared   = 0;
        mismatched = 0;
        model_hi   = 32'd0;
        model_lo   = 32'd0;
        iRST       = 1'b1;
        iStart     = 1'b0;
        iOp        = 3'b000;
        iA         = 32'd0;
        iB         = 32'd0;
        repeat (3) @(negedge iCLK);
        iRST = 1'b0;
        @(negedge iCLK);
        check("reset_busy", {31'd0, oBusy}, 32'd0);
        check("reset_done", {31'd0, oDone}, 32'd0);
        check("reset_divzero", {31'd0, oDivZero}, 32'd0);
        check("reset_hi", oHI, 32'd0);
        check("reset_lo", oLO, 32'd0);

        run_iter(OP_MULT, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0, 0);
        run_iter(OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 0);
        run_iter(OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 0);
        run_iter(OP_DIV, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 1'b0, 0);
        run_iter(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0, 0);
        run_iter(OP_DIV, 32'd123, 32'd0, 32'd123, 32'hFFFF_FFFF, 1'b1, 0);
        check("divzero_sticky", {31'd0, oDivZero}, 32'd1);
        run_iter(OP_MULTU, 32'd2, 32'd3, 32'd0, 32'd6, 1'b0, 0);
        run_iter(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 6);
        repeat (3) @(negedge iCLK);
        check("ignored_start_no_busy", {31'd0, oBusy}, 32'd0);

        // MTHI, then a divide aborted by reset at its tenth step edge
        move_to(OP_MTHI, 32'hA5A5_A5A5);
        @(negedge iCLK);
        iStart = 1'b1;
        iOp    = OP_DIV;
        iA     = 32'd50;
        iB     = 32'd5;
        @(negedge iCLK);
        iStart = 1'b0;
        check("abort_busy_before", {31'd0, oBusy}, 32'd1);
        repeat (9) @(negedge iCLK);
        iRST = 1'b1;
        @(negedge iCLK);
        iRST     = 1'b0;
        model_hi = 32'd0;
        model_lo = 32'd0;
        check("abort_hi", oHI, 32'd0);
        check("abort_lo", oLO, 32'd0);
        check("abort_busy", {31'd0, oBusy}, 32'd0);
        repeat (40) @(negedge iCLK);
        check("abort_still_idle", {31'd0, oBusy}, 32'd0);

        move_to(OP_MTLO, 32'd10);
        move_to(OP_MTHI, 32'd0);
`ifdef MULDIV_MADD_EN
        run_iter(OP_MADD, 32'd4, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 0);
        run_iter(OP_MSUB, 32'd4, 32'hFFFF_FFFD, 32'd0, 32'd10, 1'b0, 0);
`else
        @(negedge iCLK);
        iStart = 1'b1;
        iOp    = OP_MADD;
        iA     = 32'd4;
        iB     = 32'hFFFF_FFFD;
        @(negedge iCLK);
        iStart = 1'b0;
        check("madd_off_busy", {31'd0, oBusy}, 32'd0);
        repeat (40) @(negedge iCLK);
        check("madd_off_busy_late", {31'd0, oBusy}, 32'd0);
        check("madd_off_lo", oLO, 32'd10);
        check("madd_off_hi", oHI, 32'd0);
`endif

        repeat (3) @(negedge iCLK);
        check("pending_results", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
